// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operation
// encodings, FSM state encodings and small op-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage side of the multiply/divide unit: launch/abort controls,
// direct HI/LO writes, and the status/result outputs.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for
// multiply, restoring trial subtraction (one quotient bit) for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   m_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, m_i} : '0);
    // Partial remainder shifted left with the next dividend bit pulled in.
    assign trial   = acc_i[2*WIDTH-1:WIDTH-1];
    assign fits    = trial >= {1'b0, m_i};
    assign rem_sub = trial[WIDTH-1:0] - m_i;

    always_comb begin
        if (!op_is_div(op_i)) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else if (fits) begin
            acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide with architectural HI/LO.
// Operands are made positive in PREP, iterated WIDTH times, sign-fixed in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               done_q, done_d, dbz_q, dbz_d;
    logic               is_div, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .m_i   (m_q),
        .acc_o (acc_step)
    );

    assign is_div = op_is_div(op_q);
    assign sign_a = op_is_signed(op_q) & a_q[WIDTH-1];
    assign sign_b = op_is_signed(op_q) & b_q[WIDTH-1];
    assign abs_a  = sign_a ? -a_q : a_q;
    assign abs_b  = sign_b ? -b_q : b_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = ST_PREP;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    dbz_d   = 1'b0;
                end else if (!bus.start) begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            ST_PREP: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (is_div && b_q == '0) begin
                    state_d = ST_IDLE;
                    hi_d    = a_q;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    // Multiplier / dividend starts in the low half so it shifts out as bits are consumed.
                    m_d      = is_div ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = is_div ? sign_a : (sign_a ^ sign_b);
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = ST_FIX;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div) begin
                        {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                    end else begin
                        lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results,
// randomized ops against an arithmetic reference, plus flush/reset/write cases.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain wide/signed arithmetic, SV division truncates toward zero.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        z = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        if (op == OP_MULTU) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            {h, l} = p;
        end else if (op == OP_MULT) begin
            p = sa * sb;
            {h, l} = p;
        end else if (b == '0) begin
            h = a;
            l = '1;
            z = 1'b1;
        end else if (op == OP_DIVU) begin
            l = a / b;
            h = a % b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[W-1:0];
            h = r[W-1:0];
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '1;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                          input bit glitch, input bit wr_start);
        int  lat, n;
        bit  busy_ok;
        lat = (op_is_div(op) && b == '0) ? 2 : LAT;
        check("idle_pre", W'(bus.busy), W'(0));
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (wr_start) begin
            bus.lo_we = 1'b1;
            bus.wdata = ~cur_lo;
        end
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.lo_we = 1'b0;
                check("dbz_clr", W'(bus.div_by_zero), W'(0));
                if (wr_start) check("wr_start_drop", bus.lo, cur_lo);
            end
            if (glitch && lat > 6 && n == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(0, 3));
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hA5A5A5A5;
            end
            if (glitch && n == 6) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end while (!bus.done && n < 100);
        check("done_cycle", W'(n), W'(lat));
        check("busy_run", W'(busy_ok), W'(1));
        check("busy_done", W'(bus.busy), W'(0));
        check("hi", bus.hi, ehi);
        check("lo", bus.lo, elo);
        check("dbz", W'(bus.div_by_zero), W'(edbz));
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b done@%0d", op, a, b, bus.hi, bus.lo,
                 bus.div_by_zero, n);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    logic [1:0]   d_op  [8] = '{OP_MULTU, OP_MULT, OP_MULT, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_MULTU};
    logic [W-1:0] d_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9,
                                32'h80000000, 32'h00001234, 32'd3};
    logic [W-1:0] d_b   [8] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd2, 32'd2,
                                32'hFFFFFFFF, 32'd0, 32'd4};
    logic [W-1:0] d_hi  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1, 32'hFFFFFFFF,
                                32'd0, 32'h00001234, 32'd0};
    logic [W-1:0] d_lo  [8] = '{32'h00000001, 32'hFFFFFFF1, 32'd1, 32'd3, 32'hFFFFFFFD,
                                32'h80000000, 32'hFFFFFFFF, 32'd12};
    logic         d_dbz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb, rh, rl;
        logic         rz;
        int           seen;

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_dbz", W'(bus.div_by_zero), W'(0));
        check("rst_hi", bus.hi, W'(0));
        check("rst_lo", bus.lo, W'(0));

        // Direct writes in idle.
        bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        check("lo_we", bus.lo, 32'hA5A5A5A5);
        check("lo_we_hi", bus.hi, W'(0));
        bus.hi_we = 1'b1; bus.wdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("hi_we", bus.hi, 32'h5A5A5A5A);
        cur_hi = 32'h5A5A5A5A;
        cur_lo = 32'hA5A5A5A5;
        $display("direct write hi=%h lo=%h", bus.hi, bus.lo);

        // Directed cases, issued back-to-back in each done cycle.
        for (int i = 0; i < 8; i++)
            run_op(d_op[i], d_a[i], d_b[i], d_hi[i], d_lo[i], d_dbz[i], (i == 3), (i == 0));

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            model(rop, ra, rb, rh, rl, rz);
            run_op(rop, ra, rb, rh, rl, rz, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
        @(posedge clk); #1;
        check("done_pulse", W'(bus.done), W'(0));

        // Flush in cycle 10 of a multiply.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = W'($urandom) | 32'h1; bus.b = W'($urandom) | 32'h1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.start = 1'b0;
        end
        check("flush_pre_busy", W'(bus.busy), W'(1));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", W'(bus.busy), W'(0));
        check("flush_hi", bus.hi, cur_hi);
        check("flush_lo", bus.lo, cur_lo);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        check("flush_nodone", W'(seen), W'(0));
        check("flush_hi_late", bus.hi, cur_hi);
        $display("flush hi=%h lo=%h done_seen=%0d", bus.hi, bus.lo, seen);

        // Reset in cycle 20 of a divide.
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'hFFFFFFFF; bus.b = 32'd3;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", W'(bus.busy), W'(0));
        check("mid_rst_done", W'(bus.done), W'(0));
        check("mid_rst_dbz", W'(bus.div_by_zero), W'(0));
        check("mid_rst_hi", bus.hi, W'(0));
        check("mid_rst_lo", bus.lo, W'(0));
        $display("mid-op reset hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
        @(posedge clk); #1;
        rst = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd3, 32'd0, 32'h55555555, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle integer multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. Supersedes the ALU-sharing shift-add multiplier with a self-contained radix-2 datapath covering signed/unsigned multiply and divide. The hazard unit stalls on `busy`, and `flush` aborts. Results land in HI/LO, which are also writable directly (MTHI/MTLO).

## Interface
- `WIDTH`, 32: operand/result width; even, ≥4.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  launch operation; accepted only when idle.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`, `b`  in  WIDTH  operands (multiplicand/dividend, multiplier/divisor); sampled on accepting edge.
- `flush`  in  1  abort in-flight operation.
- `hi_we`, `lo_we`  in  1  direct HI/LO write enables.
- `wdata`  in  WIDTH  direct write data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `div_by_zero`  out  1  last completed op was a divide by zero; cleared on next accepted start.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.

## Operation
- States: IDLE, PREP, RUN, FIX.
  - IDLE: `start` → PREP (latch op, a, b).
  - PREP: absolute values for signed ops; record result sign (product: sign(a)^sign(b); quotient: sign(a)^sign(b); remainder: sign(a)). Divide with b==0 → IDLE with hi=a, lo=all ones, div_by_zero=1, done=1. Otherwise → RUN, counter=0.
  - RUN: one bit per cycle, exactly WIDTH cycles. Multiply: shift-add into 2·WIDTH accumulator. Divide: restoring division, quotient bit per cycle. → FIX when counter==WIDTH-1.
  - FIX: two's-complement negate results per recorded signs; write {hi,lo}=product, or lo=quotient / hi=remainder; done=1; → IDLE.
- Signed overflow DIV (−2^(WIDTH−1) / −1): lo=−2^(WIDTH−1), hi=0 (natural wrap, no flag).
- `busy` = state≠IDLE.
- `start` while busy: ignored.
- Direct writes: take effect on edge only in IDLE with `start` low. Dropped if busy or start accepted same cycle.
- `flush`: any state → IDLE next edge. hi/lo/div_by_zero unchanged, no done. `flush` has priority over `start` in IDLE.
- `rst` (any time, mid-op included): state IDLE; busy, done, div_by_zero, hi, lo all 0.

## Timing
- `start` high in cycle 0 (idle): busy high cycles 1..WIDTH+2. done and new hi/lo in cycle WIDTH+3 (35 for WIDTH=32).
- Divide by zero: done in cycle 2.
- New `start` may be accepted in the done cycle (state already IDLE).
- `done` never high for two consecutive cycles.

## Structure
- Package `muldiv_pkg`: op encodings (OP_MULTU/MULT/DIVU/DIV), state enum.
- Counter width $clog2(WIDTH).
- One natural sub-module `muldiv_step`: combinational single-iteration step (add-or-skip / trial-subtract), selected by op.
- FSM, operand/accumulator registers, and HI/LO live in top.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly cycle 35; busy cycles 1–34.
- MULT 0xFFFFFFFD(−3)×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT −1×−1 → hi=0, lo=1.
- DIVU 7/2 → lo=3, hi=1. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234/0 → done cycle 2, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. Next start clears div_by_zero.
- Flush in cycle 10 → busy low cycle 11, no done, hi/lo keep prior values. Start pulses while busy ignored. rst in cycle 20 → all outputs 0 immediately.
- lo_we with wdata=0xA5A5A5A5 in idle → lo updated next cycle. Same write while busy, or with start → dropped. Start in done cycle → accepted, result after 35 more cycles.
